if_bpu: RTL

IF_BPU -- requirements
Module: if_bpu

---
 rtl/if_bpu.sv | 129 ++++++++++++
 1 files changed

// File: rtl/if_bpu.sv
// Static branch predictor for the IF stage: backward branches and all jumps are taken.
// jalr bases other than x0 may stall IF until their register is safe to use.
module if_bpu #(
  parameter int PC_SIZE     = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_SIZE-1:0]     pc,
  input  logic                   dec_i_valid,
  input  logic                   dec_jal,
  input  logic                   dec_jalr,
  input  logic                   dec_bxx,
  input  logic [PC_SIZE-1:0]     dec_bjp_imm,
  input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
  input  logic                   if_flush,
  input  logic                   oitf_empty,
  input  logic                   ir_valid,
  input  logic                   ir_valid_clr,
  input  logic                   ir_rdwen,
  input  logic [RFIDX_WIDTH-1:0] ir_rdidx,
  input  logic                   ir_rs1en,
  input  logic [PC_SIZE-1:0]     rf2bpu_x1,
  input  logic [PC_SIZE-1:0]     rf2bpu_rs1,
  input  logic                   cnt_clr,
  output logic                   prdt_taken,
  output logic [PC_SIZE-1:0]     prdt_pc,
  output logic                   bpu_wait,
  output logic                   bpu2rf_rs1_ena,
  output logic [15:0]            wait_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DEP_WAIT,
    RD_RF
  } state_t;

  state_t state;
  state_t state_nxt;

  logic jalr_x0;
  logic jalr_x1;
  logic dep_x1;
  logic dep_xn;
  logic valid_jalr;
  logic [PC_SIZE-1:0] op1;

  assign jalr_x0    = (dec_jalr_rs1idx == '0);
  assign jalr_x1    = (dec_jalr_rs1idx == RFIDX_WIDTH'(1));
  assign valid_jalr = dec_i_valid & dec_jalr;

  // x1 has its own read path, so only a pending write to x1 blocks it; other
  // bases need RF port 1, which the IR instruction may still be holding.
  assign dep_x1 = ~oitf_empty | (ir_valid & ir_rdwen & (ir_rdidx == RFIDX_WIDTH'(1)));
  assign dep_xn = ~oitf_empty | (ir_valid & ir_rs1en & ~ir_valid_clr);

  assign prdt_taken = dec_i_valid & (dec_jal | dec_jalr | (dec_bxx & dec_bjp_imm[PC_SIZE-1]));

  always_comb begin
    op1 = pc;
    if (dec_jalr) begin
      if (jalr_x0)      op1 = '0;
      else if (jalr_x1) op1 = rf2bpu_x1;
      else              op1 = rf2bpu_rs1;
    end
  end

  assign prdt_pc = op1 + dec_bjp_imm;

  always_comb begin
    state_nxt      = state;
    bpu_wait       = 1'b0;
    bpu2rf_rs1_ena = 1'b0;
    case (state)
      IDLE: begin
        if (valid_jalr && !jalr_x0) begin
          if (jalr_x1) begin
            if (dep_x1) begin
              state_nxt = DEP_WAIT;
              bpu_wait  = 1'b1;
            end
          end else if (dep_xn) begin
            state_nxt = DEP_WAIT;
            bpu_wait  = 1'b1;
          end else begin
            state_nxt      = RD_RF;
            bpu2rf_rs1_ena = 1'b1;
            bpu_wait       = 1'b1;
          end
        end
      end
      DEP_WAIT: begin
        if (jalr_x1) begin
          if (dep_x1) bpu_wait  = 1'b1;
          else        state_nxt = IDLE;
        end else if (dep_xn) begin
          bpu_wait = 1'b1;
        end else begin
          state_nxt      = RD_RF;
          bpu2rf_rs1_ena = 1'b1;
          bpu_wait       = 1'b1;
        end
      end
      RD_RF:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Flush and reset abandon whatever jalr was being resolved.
    if (rst || if_flush) begin
      state_nxt      = IDLE;
      bpu_wait       = 1'b0;
      bpu2rf_rs1_ena = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)
        wait_cnt <= '0;
      else if (bpu_wait && (wait_cnt != 16'hFFFF))
        wait_cnt <= wait_cnt + 16'd1;
    end
  end

endmodule
